// File: rtl/psel_gen_pkg.sv
// Shared helpers for the multi-grant fixed-priority selector.
package psel_gen_pkg;

  // Bits needed to count 0..reqs grants.
  function automatic int cnt_w(input int reqs);
    return $clog2(reqs + 1);
  endfunction

endpackage

// File: rtl/psel_gen_lsb_sel.sv
// One cascade stage: isolates the lowest set bit of a request mask as a one-hot.
module psel_gen_lsb_sel #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] pick
);

  // Two's complement trick: mask & -mask keeps only the lowest set bit (0 if mask==0).
  always_comb pick = mask & (-mask);

endmodule

// File: rtl/psel_gen.sv
// Multi-grant fixed-priority selector: grants up to REQS of WIDTH requests,
// lowest index first, with combinational grants and registered mirrors.
module psel_gen
  import psel_gen_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int REQS  = 3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             req,
  output logic [WIDTH-1:0]             gnt,
  output logic [REQS-1:0][WIDTH-1:0]   gnt_bus,
  output logic [$clog2(REQS+1)-1:0]    gnt_cnt,
  output logic [WIDTH-1:0]             gnt_q,
  output logic [REQS-1:0][WIDTH-1:0]   gnt_bus_q
);

  localparam int CNT_W = cnt_w(REQS);

  // mask[k] = requests still unserved when stage k looks at them
  logic [REQS-1:0][WIDTH-1:0] mask;

  assign mask[0] = req;

  genvar k;
  generate
    for (k = 0; k < REQS; k++) begin : g_stage
      psel_gen_lsb_sel #(.WIDTH(WIDTH)) u_sel (
        .mask (mask[k]),
        .pick (gnt_bus[k])
      );
      // The last stage's leftover mask has no consumer, so it is never built.
      if (k < REQS - 1) begin : g_next
        assign mask[k+1] = mask[k] & ~gnt_bus[k];
      end
    end
  endgenerate

  // Flat grant is the union of the mutually exclusive rows.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < REQS; i++) gnt = gnt | gnt_bus[i];
  end

  // A row is either one-hot or zero, so counting non-empty rows counts grants.
  always_comb begin
    gnt_cnt = '0;
    for (int i = 0; i < REQS; i++) gnt_cnt = gnt_cnt + CNT_W'(|gnt_bus[i]);
  end

  // Registered mirrors for debug / timing-closure users; async clear on reset low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gnt_q     <= '0;
      gnt_bus_q <= '0;
    end else begin
      gnt_q     <= gnt;
      gnt_bus_q <= gnt_bus;
    end
  end

endmodule

// File: tb/tb_psel_gen.sv
// Scoreboard bench for psel_gen: main config (6,3) plus REQS=1 and REQS>WIDTH.
module tb_psel_gen;

  logic clock = 1'b0;
  logic reset = 1'b0;

  // main instance WIDTH=6 REQS=3
  logic [5:0]      req0;
  logic [5:0]      gnt0, gntq0;
  logic [2:0][5:0] bus0, busq0;
  logic [1:0]      cnt0;
  // REQS=1
  logic [5:0]      req1;
  logic [5:0]      gnt1, gntq1;
  logic [0:0][5:0] bus1, busq1;
  logic [0:0]      cnt1;
  // REQS > WIDTH
  logic [1:0]      req2;
  logic [1:0]      gnt2, gntq2;
  logic [2:0][1:0] bus2, busq2;
  logic [1:0]      cnt2;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_t;

  sb_t comb_q[$];
  sb_t reg_q[$];

  always #5 clock = ~clock;

  psel_gen #(.WIDTH(6), .REQS(3)) u0 (
    .clock(clock), .reset(reset), .req(req0), .gnt(gnt0), .gnt_bus(bus0),
    .gnt_cnt(cnt0), .gnt_q(gntq0), .gnt_bus_q(busq0));

  psel_gen #(.WIDTH(6), .REQS(1)) u1 (
    .clock(clock), .reset(reset), .req(req1), .gnt(gnt1), .gnt_bus(bus1),
    .gnt_cnt(cnt1), .gnt_q(gntq1), .gnt_bus_q(busq1));

  psel_gen #(.WIDTH(2), .REQS(3)) u2 (
    .clock(clock), .reset(reset), .req(req2), .gnt(gnt2), .gnt_bus(bus2),
    .gnt_cnt(cnt2), .gnt_q(gntq2), .gnt_bus_q(busq2));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] act(input string tag);
    case (tag)
      "gnt0":  return 64'(gnt0);
      "bus0":  return 64'(bus0);
      "cnt0":  return 64'(cnt0);
      "gnt1":  return 64'(gnt1);
      "bus1":  return 64'(bus1);
      "cnt1":  return 64'(cnt1);
      "gnt2":  return 64'(gnt2);
      "bus2":  return 64'(bus2);
      "cnt2":  return 64'(cnt2);
      "gntq0": return 64'(gntq0);
      "busq0": return 64'(busq0);
      "gntq1": return 64'(gntq1);
      "busq1": return 64'(busq1);
      "gntq2": return 64'(gntq2);
      "busq2": return 64'(busq2);
      default: return '1;
    endcase
  endfunction

  // Reference: walk bits upward, the c-th set bit found goes to row c.
  task automatic model(input int w, input int r, input logic [63:0] rq,
                       output logic [63:0] g, output logic [63:0] b, output int c);
    g = '0; b = '0; c = 0;
    for (int i = 0; i < w; i++) begin
      if (rq[i] && c < r) begin
        b[c*w + i] = 1'b1;
        g[i] = 1'b1;
        c++;
      end
    end
  endtask

  task automatic push_all(input logic [5:0] r);
    logic [63:0] g, b;
    int c;
    model(6, 3, 64'(r), g, b, c);
    comb_q.push_back('{"gnt0", g}); comb_q.push_back('{"bus0", b}); comb_q.push_back('{"cnt0", 64'(c)});
    reg_q.push_back('{"gntq0", g});  reg_q.push_back('{"busq0", b});
    model(6, 1, 64'(r), g, b, c);
    comb_q.push_back('{"gnt1", g}); comb_q.push_back('{"bus1", b}); comb_q.push_back('{"cnt1", 64'(c)});
    reg_q.push_back('{"gntq1", g});  reg_q.push_back('{"busq1", b});
    model(2, 3, 64'(r[1:0]), g, b, c);
    comb_q.push_back('{"gnt2", g}); comb_q.push_back('{"bus2", b}); comb_q.push_back('{"cnt2", 64'(c)});
    reg_q.push_back('{"gntq2", g});  reg_q.push_back('{"busq2", b});
  endtask

  task automatic drain_comb();
    sb_t e;
    while (comb_q.size() > 0) begin
      e = comb_q.pop_front();
      chk(e.tag, act(e.tag), e.exp);
    end
  endtask

  task automatic drain_reg();
    sb_t e;
    while (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      chk(e.tag, act(e.tag), e.exp);
    end
  endtask

  // Invariants on the main instance, independent of the model.
  task automatic chk_inv();
    int rows;
    rows = 0;
    for (int k = 0; k < 3; k++) rows += $countones(bus0[k]);
    chk("subset", 64'(gnt0 & ~req0), 64'd0);
    chk("popcnt", 64'($countones(gnt0)), 64'(cnt0));
    chk("excl",   64'(rows), 64'($countones(gnt0)));
  endtask

  // One vector: drive at negedge, check comb #1 later, check registers after the edge.
  task automatic apply(input logic [5:0] r);
    @(negedge clock);
    req0 = r; req1 = r; req2 = r[1:0];
    push_all(r);
    #1;
    drain_comb();
    chk_inv();
    @(posedge clock);
    #1;
    drain_reg();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] perm [64];
    logic [5:0] tmp;
    int j;

    req0 = '0; req1 = '0; req2 = '0;
    #1;
    chk("rst_gntq", 64'(gntq0), 64'd0);
    chk("rst_busq", 64'(busq0), 64'd0);
    chk("rst_gnt",  64'(gnt0),  64'd0);
    @(negedge clock);
    reset = 1'b1;

    // directed vectors
    apply(6'b000000);
    apply(6'b101101);
    chk("tp_gnt",  64'(gnt0), 64'b001101);
    chk("tp_bus",  64'(bus0), 64'({6'b001000, 6'b000100, 6'b000001}));
    chk("tp_cnt",  64'(cnt0), 64'd3);
    apply(6'b100000);
    chk("tp_hi",   64'(bus0), 64'({6'b0, 6'b0, 6'b100000}));
    apply(6'b111111);
    chk("tp_all",  64'(gnt0), 64'b000111);
    chk("tp_w2",   64'(bus2[2]), 64'd0);
    apply(6'b110000);
    chk("tp_top",  64'(bus0), 64'({6'b0, 6'b100000, 6'b010000}));
    apply(6'b011010);
    chk("tp_busq", 64'(busq0), 64'({6'b010000, 6'b001000, 6'b000010}));

    // async reset mid-cycle: registers clear without an edge, comb path unaffected
    #2;
    reset = 1'b0;
    #1;
    chk("arst_gntq", 64'(gntq0), 64'd0);
    chk("arst_busq", 64'(busq0), 64'd0);
    chk("arst_gnt",  64'(gnt0),  64'b011010);
    @(posedge clock);
    #1;
    chk("hold_gntq", 64'(gntq0), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("rel_gntq", 64'(gntq0), 64'b011010);
    chk("rel_busq", 64'(busq0), 64'({6'b010000, 6'b001000, 6'b000010}));

    // shuffled sweep of all 64 request values
    for (int i = 0; i < 64; i++) perm[i] = 6'(i);
    for (int i = 63; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int i = 0; i < 64; i++) apply(perm[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
